scan_sel_gen: RTL and testbench
===============================

// Module: scan_sel_gen
// PURPOSE
//  Upstream address sequencer for the 3-to-8 decoder stage: walks a masked set of the 8 channels
//  and drives the decoder's 3-bit select, holding each channel for a programmable dwell.
//  Single-pass or continuous scan. Control is start/stop pulses; status is busy/done/advance strobes.
//  Sits between the control register block and the 3x8 decoder (sel -> decoder i[2:0]).
// PARAMETERS
//  DWELL_W  8  width of dwell count (cycles each channel is held)
// PORTS
//  clk        in   1        single clock, rising edge
//  rst_n      in   1        asynchronous, active-low reset
//  start      in   1        pulse: begin scan (ignored while busy)
//  stop       in   1        pulse: abort scan
//  mode       in   1        0 = single pass, 1 = continuous (wrap)
//  ch_mask    in   8        1 = visit channel; sampled on accepted start
//  dwell      in   DWELL_W  cycles per channel; 0 treated as 1; sampled on accepted start
//  sel        out  3        channel index to decoder
//  sel_valid  out  1        sel is live; gate the decoder enable with this
//  busy       out  1        scan in progress
//  ch_adv     out  1        1-cycle pulse when sel moves to a new (or same, on wrap) channel
//  done       out  1        1-cycle pulse at end of a single-pass scan
// BEHAVIOUR
//  - Reset (async assert, sync release): state IDLE; sel=0, sel_valid=0, busy=0, ch_adv=0,
//    done=0, dwell counter=0, captured mask/mode/dwell=0. Reset mid-scan aborts without done.
//  - States: IDLE, ACTIVE. All outputs registered.
//  - IDLE: start=1, stop=0, ch_mask!=0 -> next cycle: ACTIVE, sel=lowest set bit of ch_mask,
//    sel_valid=1, busy=1, ch_adv=1, cnt=max(dwell,1)-1; mask/mode/dwell captured.
//    Latency start->sel_valid = 1 cycle.
//  - IDLE: start with ch_mask==0 -> done=1 for one cycle next cycle; stays IDLE, sel unchanged.
//  - IDLE: start and stop same cycle -> stop wins, start ignored.
//  - ACTIVE, stop=1 -> next cycle IDLE, sel_valid=0, busy=0, no done, no ch_adv; sel holds.
//  - ACTIVE, stop=0, cnt!=0 -> cnt decrements; sel unchanged.
//  - ACTIVE, stop=0, cnt==0: find next set bit of captured mask with index > sel:
//    found -> sel=that index, ch_adv=1, cnt reload.
//    none, mode=1 -> sel=lowest set bit (may equal sel), ch_adv=1, cnt reload.
//    none, mode=0 -> IDLE, sel_valid=0, busy=0, done=1 (one cycle); sel holds last index.
//  - Each channel is held exactly max(dwell,1) cycles with sel_valid=1.
//  - start while busy ignored; ch_mask/dwell/mode changes while busy have no effect.
//  - stop in IDLE: no effect. stop has priority over dwell expiry.
//  - mode sampled once; continuous scan only ends on stop or reset.
// STRUCTURE
//  - Shared package: N_CH=8, SEL_W=3, state enum {IDLE, ACTIVE}.
//  - One sub-module: next_ch_find (combinational): inputs mask[7:0], cur[2:0]; outputs
//    nxt[2:0], found (next set bit above cur), first[2:0] (lowest set bit).
//  - Top holds FSM, dwell counter, capture registers, output registers.
// TESTING
//  1 mask=8'b1010_0101, dwell=2, mode=0, start -> sel 0,0,2,2,5,5,7,7; ch_adv on each
//    change; done pulse the cycle after the last 7; sel_valid low same cycle as done.
//  2 mask=8'h81, dwell=0, mode=1 -> sel 0,7,0,7,... one cycle each; ch_adv every cycle; no done.
//  3 mask=8'h10, dwell=3, mode=1 -> sel=4 constant, ch_adv every 3rd cycle; stop -> next cycle
//    busy=0, sel_valid=0, no done.
//  4 start with mask=8'h00 -> done pulse one cycle later, busy stays 0, sel_valid stays 0.
//  5 mid-scan: change mask/dwell and pulse start -> sequence unaffected;
//    start+stop same cycle in IDLE -> stays IDLE.
//  6 rst_n low during ACTIVE (async, between clock edges) -> all outputs 0 immediately; after
//    release, new start scans normally from the lowest set bit.

Source files
------------

// File: rtl/scan_sel_gen_pkg.sv
// scan_sel_gen_pkg: shared constants and state type for the decoder select sequencer.
// Holds the channel count, select width and the two-state FSM enum.
package scan_sel_gen_pkg;

    localparam int N_CH  = 8;
    localparam int SEL_W = 3;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

endpackage

// File: rtl/scan_sel_gen_next_ch_find.sv
// next_ch_find: combinational search over a channel mask.
// Ports: mask/cur in; nxt (next set bit above cur), found, first (lowest set bit) out.
module next_ch_find
    import scan_sel_gen_pkg::*;
(
    input  logic [N_CH-1:0]  mask,
    input  logic [SEL_W-1:0] cur,
    output logic [SEL_W-1:0] nxt,
    output logic             found,
    output logic [SEL_W-1:0] first
);

    // Descending scans: the last hit is the lowest qualifying index.
    always_comb begin
        nxt   = '0;
        found = 1'b0;
        first = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (mask[i] && (i > int'(cur))) begin
                nxt   = SEL_W'(i);
                found = 1'b1;
            end
            if (mask[i]) begin
                first = SEL_W'(i);
            end
        end
    end

endmodule

// File: rtl/scan_sel_gen.sv
// scan_sel_gen: walks a masked channel set, holding each select for a dwell.
// Ports: clk, rst_n, start/stop/mode/ch_mask/dwell in; sel/sel_valid/busy/ch_adv/done out.
module scan_sel_gen
    import scan_sel_gen_pkg::*;
#(
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic               mode,
    input  logic [N_CH-1:0]    ch_mask,
    input  logic [DWELL_W-1:0] dwell,
    output logic [SEL_W-1:0]   sel,
    output logic               sel_valid,
    output logic               busy,
    output logic               ch_adv,
    output logic               done
);

    state_t             r_state;
    logic [SEL_W-1:0]   r_sel;
    logic               r_sel_valid;
    logic               r_busy;
    logic               r_ch_adv;
    logic               r_done;
    logic [DWELL_W-1:0] r_cnt;
    logic [N_CH-1:0]    r_mask;
    logic               r_mode;
    logic [DWELL_W-1:0] r_dwell;

    logic [N_CH-1:0]    w_fmask;
    logic [SEL_W-1:0]   w_nxt;
    logic               w_found;
    logic [SEL_W-1:0]   w_first;
    logic [DWELL_W-1:0] w_start_cnt;
    logic [DWELL_W-1:0] w_reload;

    // One finder serves both states: live mask in IDLE, captured in ACTIVE.
    assign w_fmask = (r_state == IDLE) ? ch_mask : r_mask;

    // A zero dwell behaves as one cycle per channel.
    assign w_start_cnt = (dwell == '0) ? '0
                       : dwell - DWELL_W'(1);
    assign w_reload    = (r_dwell == '0) ? '0
                       : r_dwell - DWELL_W'(1);

    next_ch_find u_find (
        .mask  (w_fmask),
        .cur   (r_sel),
        .nxt   (w_nxt),
        .found (w_found),
        .first (w_first)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_sel       <= '0;
            r_sel_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_ch_adv    <= 1'b0;
            r_done      <= 1'b0;
            r_cnt       <= '0;
            r_mask      <= '0;
            r_mode      <= 1'b0;
            r_dwell     <= '0;
        end else begin
            r_ch_adv <= 1'b0;
            r_done   <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (start && !stop) begin
                        if (ch_mask != '0) begin
                            r_state     <= ACTIVE;
                            r_sel       <= w_first;
                            r_sel_valid <= 1'b1;
                            r_busy      <= 1'b1;
                            r_ch_adv    <= 1'b1;
                            r_cnt       <= w_start_cnt;
                            r_mask      <= ch_mask;
                            r_mode      <= mode;
                            r_dwell     <= dwell;
                        end else begin
                            r_done <= 1'b1;
                        end
                    end
                end
                ACTIVE: begin
                    if (stop) begin
                        r_state     <= IDLE;
                        r_sel_valid <= 1'b0;
                        r_busy      <= 1'b0;
                    end else if (r_cnt != '0) begin
                        r_cnt <= r_cnt - DWELL_W'(1);
                    end else if (w_found) begin
                        r_sel    <= w_nxt;
                        r_ch_adv <= 1'b1;
                        r_cnt    <= w_reload;
                    end else if (r_mode) begin
                        r_sel    <= w_first;
                        r_ch_adv <= 1'b1;
                        r_cnt    <= w_reload;
                    end else begin
                        r_state     <= IDLE;
                        r_sel_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_done      <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign sel       = r_sel;
    assign sel_valid = r_sel_valid;
    assign busy      = r_busy;
    assign ch_adv    = r_ch_adv;
    assign done      = r_done;

endmodule

// File: tb/tb_scan_sel_gen.sv
// tb_scan_sel_gen: random and directed scans against a cycle-indexed scan model.
// Outputs are packed {sel, sel_valid, busy, ch_adv, done} and compared every cycle.
module tb_scan_sel_gen;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       stop;
    logic       mode;
    logic [7:0] ch_mask;
    logic [7:0] dwell;
    logic [2:0] sel;
    logic       sel_valid;
    logic       busy;
    logic       ch_adv;
    logic       done;
    logic [6:0] obs;

    int n_chk = 0;
    int n_bad = 0;

    // scenario model state
    int         q_ch[$];
    int         hold;
    bit         cont;
    int         stop_at;
    logic [2:0] base_sel;

    scan_sel_gen #(.DWELL_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .stop      (stop),
        .mode      (mode),
        .ch_mask   (ch_mask),
        .dwell     (dwell),
        .sel       (sel),
        .sel_valid (sel_valid),
        .busy      (busy),
        .ch_adv    (ch_adv),
        .done      (done)
    );

    always #5 clk = ~clk;

    assign obs = {sel, sel_valid, busy, ch_adv, done};

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Channel visited at scan cycle k: list in ascending order, each
    // repeated hold times, list repeating in continuous mode.
    function automatic logic [2:0] ch_at(int k);
        return 3'(q_ch[(k / hold) % q_ch.size()]);
    endfunction

    // Expected packed outputs k cycles after the accepting edge.
    function automatic logic [6:0] exp_at(int k);
        int n;
        int len;
        n = q_ch.size();
        if (n == 0)
            return {base_sel, 3'b000, (k == 0)};
        len = n * hold;
        if (stop_at >= 0 && k > stop_at && (cont || stop_at < len))
            return {ch_at(stop_at), 4'b0000};
        if (cont || k < len)
            return {ch_at(k), 2'b11, (k % hold == 0), 1'b0};
        return {3'(q_ch[n-1]), 3'b000, (k == len)};
    endfunction

    task automatic run_scan(input logic [7:0] m, input int dw, input bit md,
                            input int stp, input int nc, input string tag);
        logic [6:0] e;
        q_ch.delete();
        for (int i = 0; i < 8; i++)
            if (m[i]) q_ch.push_back(i);
        hold    = (dw == 0) ? 1 : dw;
        cont    = md;
        stop_at = stp;
        start   = 1'b1;
        stop    = 1'b0;
        ch_mask = m;
        dwell   = 8'(dw);
        mode    = md;
        for (int k = 0; k < nc; k++) begin
            @(negedge clk);
            e = exp_at(k);
            chk($sformatf("%s[%0d]", tag, k), 32'(obs), 32'(e));
            // noise that must be ignored while a scan is running
            start   = e[2] ? 1'($urandom) : 1'b0;
            stop    = (k == stop_at);
            ch_mask = 8'($urandom);
            dwell   = 8'($urandom);
            mode    = 1'($urandom);
        end
        start    = 1'b0;
        stop     = 1'b0;
        base_sel = exp_at(nc - 1)[6:4];
    endtask

    initial begin
        logic [7:0] m;
        int         dw;
        bit         md;
        int         n;
        int         len;
        int         stp;
        int         nc;

        rst_n    = 1'b0;
        start    = 1'b0;
        stop     = 1'b0;
        mode     = 1'b0;
        ch_mask  = 8'h00;
        dwell    = 8'h00;
        base_sel = 3'd0;
        repeat (2) @(negedge clk);
        chk("reset", 32'(obs), 32'h0);
        rst_n = 1'b1;

        run_scan(8'b1010_0101, 2, 1'b0, -1, 11, "t1");
        run_scan(8'h81, 0, 1'b1, 9, 12, "t2");
        run_scan(8'h10, 3, 1'b1, 10, 13, "t3");
        run_scan(8'h00, 0, 1'b0, -1, 3, "t4");
        run_scan(8'h40, 255, 1'b0, -1, 258, "dw255");
        run_scan(8'h18, 1, 1'b0, 0, 3, "stop_first");

        // start and stop together in IDLE: stop wins
        start   = 1'b1;
        stop    = 1'b1;
        ch_mask = 8'hff;
        dwell   = 8'd1;
        @(negedge clk);
        chk("ss_idle", 32'(obs), 32'({base_sel, 4'b0000}));
        start = 1'b0;
        stop  = 1'b0;
        @(negedge clk);
        chk("ss_idle2", 32'(obs), 32'({base_sel, 4'b0000}));

        // async reset in the middle of a continuous scan
        run_scan(8'h66, 2, 1'b1, -1, 5, "pre_rst");
        #2 rst_n = 1'b0;
        #1 chk("async_rst", 32'(obs), 32'h0);
        @(negedge clk);
        chk("rst_hold", 32'(obs), 32'h0);
        rst_n    = 1'b1;
        base_sel = 3'd0;
        run_scan(8'h24, 1, 1'b0, -1, 5, "t6");

        for (int r = 0; r < 30; r++) begin
            m  = ($urandom % 6 == 0) ? 8'h00 : 8'($urandom);
            dw = $urandom_range(0, 4);
            md = 1'($urandom);
            n  = $countones(m);
            len = n * ((dw == 0) ? 1 : dw);
            if (n == 0) begin
                stp = -1;
                nc  = 3;
            end else if (md) begin
                stp = $urandom_range(0, 3 * len + 2);
                nc  = stp + 3;
            end else begin
                stp = ($urandom % 2 == 1) ? $urandom_range(0, len + 1) : -1;
                nc  = (stp >= 0 && stp < len) ? stp + 3 : len + 3;
            end
            run_scan(m, dw, md, stp, nc, $sformatf("rnd%0d", r));
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
